// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, default fetch parameters and the
// IF/ID bundle that both the fetch stage and the decoder consume.
package cpu_pkg;

    localparam int          XLEN                = 32;
    localparam int          IMEM_WORDS_DEFAULT  = 1000;
    localparam logic [31:0] NOP_INSTR_DEFAULT   = 32'h0000_0000;

    // Contents of the IF/ID pipeline register as seen by decode.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    // What the IF/ID register does on the next edge. A flush (redirect) and a
    // bubble (halted fetch) have identical effect, so they share one code.
    typedef enum logic [1:0] {
        IF_ID_HOLD  = 2'd0,
        IF_ID_LOAD  = 2'd1,
        IF_ID_FLUSH = 2'd2
    } if_id_action_e;

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register with load, hold and flush controls.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  if_id_action_e action,
    input  if_id_t        load_data,
    output if_id_t        q
);

    // Capture, hold or flush the pipeline register; a flush keeps pc_plus4.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            q.instr    <= NOP_INSTR;
            q.pc_plus4 <= '0;
            q.valid    <= 1'b0;
        end else begin
            case (action)
                IF_ID_LOAD: q <= load_data;
                IF_ID_FLUSH: begin
                    q.instr <= NOP_INSTR;
                    q.valid <= 1'b0;
                end
                default: ; // hold
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, presents the fetch address to instruction memory
// and feeds the returned instruction into the IF/ID register. Handles stalls,
// redirects with flush, and suspends fetch once the PC leaves memory.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = IMEM_WORDS_DEFAULT,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misaligned,
    output logic [31:0] fetch_count
);

    // Word-index limit sized to pc[31:2] so the range compare is width-matched.
    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

    logic [31:0]   pc_plus4;
    logic          in_range;
    logic          fetch_en;
    if_id_action_e if_id_action;
    if_id_t        if_id_load;
    if_id_t        if_id_q;

    assign imem_address = pc;
    assign pc_plus4     = pc + 32'd4;
    assign in_range     = (pc[31:2] < IMEM_LIMIT);
    assign halted       = !in_range;

    // A normal fetch happens only when nothing higher-priority claims the edge.
    assign fetch_en = !redirect && !stall && in_range;

    // Choose the IF/ID action: redirect > stall > halted > normal.
    always_comb begin
        // NOTE: assign a default first so no path leaves the signal unassigned
        // and a latch cannot be inferred.
        if_id_action = IF_ID_HOLD;
        if (redirect) begin
            if_id_action = IF_ID_FLUSH;
        end else if (stall) begin
            if_id_action = IF_ID_HOLD;
        end else if (!in_range) begin
            if_id_action = IF_ID_FLUSH;
        end else begin
            if_id_action = IF_ID_LOAD;
        end
    end

    assign if_id_load = '{instr: imem_instruction, pc_plus4: pc_plus4, valid: 1'b1};

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .reset     (reset),
        .action    (if_id_action),
        .load_data (if_id_load),
        .q         (if_id_q)
    );

    assign if_id_instr    = if_id_q.instr;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_valid    = if_id_q.valid;

    // PC, sticky misalignment flag and accepted-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            misaligned  <= 1'b0;
            fetch_count <= '0;
        end else if (redirect) begin
            // Low bits are dropped so fetch stays word-aligned; the flag
            // records that software asked for something else.
            pc         <= {redirect_target[31:2], 2'b00};
            misaligned <= misaligned | (redirect_target[1:0] != 2'b00);
        end else if (fetch_en) begin
            pc          <= pc_plus4;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios from the test
// plan followed by randomized traffic checked against a behavioural model.
module tb_instruction_fetch;
    import cpu_pkg::*;

    localparam int          WORDS = 1000;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] INS_A = 32'hA1A1_0001;
    localparam logic [31:0] INS_B = 32'hB2B2_0002;
    localparam logic [31:0] INS_C = 32'hC3C3_0003;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
    logic        misaligned;
    logic [31:0] fetch_count;

    logic [31:0] mem [1024];

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_mis;

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (WORDS),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_target  (redirect_target),
        .pc               (pc),
        .if_id_instr      (if_id_instr),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_valid      (if_id_valid),
        .halted           (halted),
        .misaligned       (misaligned),
        .fetch_count      (fetch_count)
    );

    always #5 clk = ~clk;

    // Combinational-read instruction memory.
    assign imem_instruction = mem[imem_address[11:2]];

    // Apply one cycle of inputs, advance the model by the fetch rules, and
    // return 1 ns after the edge with inputs back at idle.
    task automatic step(input logic r, input logic st, input logic rd, input logic [31:0] tgt);
        reset = r; stall = st; redirect = rd; redirect_target = tgt;
        if (r) begin
            m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0; m_count = 32'h0;
        end else if (rd) begin
            m_pc = tgt & 32'hFFFF_FFFC; m_valid = 1'b0; m_instr = NOP;
            if (tgt % 4 != 0) m_mis = 1'b1;
        end else if (!st) begin
            if (m_pc / 4 >= WORDS) begin
                m_valid = 1'b0; m_instr = NOP;
            end else begin
                m_instr = mem[m_pc / 4]; m_pc4 = m_pc + 4; m_valid = 1'b1;
                m_count = m_count + 1; m_pc = m_pc + 4;
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        checks++; if (imem_address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_address, 32'h0); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
        checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", if_id_instr, NOP); end
        checks++; if (if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 0", if_id_pc_plus4); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", misaligned); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_instr [3];
        exp_instr[0] = INS_A; exp_instr[1] = INS_B; exp_instr[2] = INS_C;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            checks++; if (imem_address !== 32'(4 * k)) begin errors++; $display("FAIL run_addr[%0d]: got %h want %h", k, imem_address, 32'(4 * k)); end
            checks++; if (if_id_instr !== exp_instr[k-1]) begin errors++; $display("FAIL run_instr[%0d]: got %h want %h", k, if_id_instr, exp_instr[k-1]); end
            checks++; if (if_id_pc_plus4 !== 32'(4 * k)) begin errors++; $display("FAIL run_pc4[%0d]: got %h want %h", k, if_id_pc_plus4, 32'(4 * k)); end
            checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL run_valid[%0d]: got %b want 1", k, if_id_valid); end
        end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL run_count: got %0d want 3", fetch_count); end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 8", k, pc); end
            checks++; if (if_id_instr !== INS_B) begin errors++; $display("FAIL stall_instr[%0d]: got %h want %h", k, if_id_instr, INS_B); end
            checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count[%0d]: got %0d want 2", k, fetch_count); end
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (if_id_instr !== INS_C) begin errors++; $display("FAIL stall_release_instr: got %h want %h", if_id_instr, INS_C); end
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL stall_release_pc: got %h want c", pc); end
    endtask

    // Runs from pc=12 left by test_stall.
    task automatic test_redirect_stall();
        step(1'b0, 1'b1, 1'b1, 32'h40);
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL rdst_pc: got %h want 40", pc); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rdst_valid: got %b want 0", if_id_valid); end
        checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL rdst_instr: got %h want %h", if_id_instr, NOP); end
        checks++; if (if_id_pc_plus4 !== 32'hC) begin errors++; $display("FAIL rdst_pc4_held: got %h want c", if_id_pc_plus4); end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL rdst_count: got %0d want 3", fetch_count); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (if_id_instr !== mem[16]) begin errors++; $display("FAIL rdst_next_instr: got %h want %h", if_id_instr, mem[16]); end
        checks++; if (if_id_pc_plus4 !== 32'h44) begin errors++; $display("FAIL rdst_next_pc4: got %h want 44", if_id_pc_plus4); end
    endtask

    task automatic test_misaligned();
        step(1'b0, 1'b0, 1'b1, 32'h43);
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL mis_pc: got %h want 40", pc); end
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_set: got %b want 1", misaligned); end
        step(1'b0, 1'b0, 1'b1, 32'h100);
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_sticky_redirect: got %b want 1", misaligned); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_sticky_run: got %b want 1", misaligned); end
    endtask

    task automatic test_halt();
        step(1'b0, 1'b0, 1'b1, 32'd3996);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_last_word_halted: got %b want 0", halted); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (if_id_instr !== mem[999]) begin errors++; $display("FAIL halt_last_instr: got %h want %h", if_id_instr, mem[999]); end
        checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL halt_last_valid: got %b want 1", if_id_valid); end
        checks++; if (pc !== 32'd4000) begin errors++; $display("FAIL halt_pc: got %0d want 4000", pc); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", halted); end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, (k == 2), 1'b0, 32'h0);
            checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL halt_bubble_valid[%0d]: got %b want 0", k, if_id_valid); end
            checks++; if (pc !== 32'd4000) begin errors++; $display("FAIL halt_hold_pc[%0d]: got %0d want 4000", k, pc); end
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_hold_flag[%0d]: got %b want 1", k, halted); end
        end
        checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL halt_bubble_instr: got %h want %h", if_id_instr, NOP); end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_resume: got %b want 0", halted); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL halt_resume_pc: got %h want 0", pc); end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 1'b1, 32'h41);
        step(1'b1, 1'b1, 1'b1, 32'h80);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rmid_pc: got %h want 0", pc); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", if_id_valid); end
        checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL rmid_instr: got %h want %h", if_id_instr, NOP); end
        checks++; if (if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rmid_pc4: got %h want 0", if_id_pc_plus4); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rmid_halted: got %b want 0", halted); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL rmid_mis: got %b want 0", misaligned); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rmid_count: got %0d want 0", fetch_count); end
    endtask

    task automatic test_random();
        logic        r, st, rd;
        logic [31:0] tgt;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 99) < 2);
            st  = ($urandom_range(0, 99) < 25);
            rd  = ($urandom_range(0, 99) < 10);
            tgt = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(3980, 4010))
                                              : 32'($urandom_range(0, 4095));
            step(r, st, rd, tgt);
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, pc, m_pc); end
            checks++; if (imem_address !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, imem_address, m_pc); end
            checks++; if (if_id_instr !== m_instr) begin errors++; $display("FAIL rnd_instr[%0d]: got %h want %h", n, if_id_instr, m_instr); end
            checks++; if (if_id_pc_plus4 !== m_pc4) begin errors++; $display("FAIL rnd_pc4[%0d]: got %h want %h", n, if_id_pc_plus4, m_pc4); end
            checks++; if (if_id_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, if_id_valid, m_valid); end
            checks++; if (halted !== (m_pc / 4 >= WORDS)) begin errors++; $display("FAIL rnd_halted[%0d]: got %b want %b", n, halted, (m_pc / 4 >= WORDS)); end
            checks++; if (misaligned !== m_mis) begin errors++; $display("FAIL rnd_mis[%0d]: got %b want %b", n, misaligned, m_mis); end
            checks++; if (fetch_count !== m_count) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, fetch_count, m_count); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = INS_A; mem[1] = INS_B; mem[2] = INS_C;
        @(posedge clk);
        #1;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_misaligned();
        test_halt();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction memory: owns the program counter, drives the word-aligned fetch address, and captures the returned instruction into the IF/ID pipeline register for the decoder.
- Handles sequential PC+4 advance, a stall from the hazard unit, a redirect (branch/jump) from a later stage with IF/ID flush, and an out-of-range halt against the instruction memory depth.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_WORDS, 1000, instruction memory depth in 32-bit words; word index >= IMEM_WORDS is out of range.
- NOP_INSTR, 32'h0000_0000, value placed in if_id_instr on flush or bubble.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- imem_address  output  32  fetch byte address to instruction memory; equals pc.
- imem_instruction  input  32  instruction returned by memory for imem_address, valid in the same cycle (combinational read).
- stall  input  1  hold PC and IF/ID this cycle.
- redirect  input  1  branch/jump taken; load redirect_target.
- redirect_target  input  32  new PC byte address.
- pc  output  32  current PC.
- if_id_instr  output  32  registered instruction to decode.
- if_id_pc_plus4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  PC is out of memory range; fetch suspended.
- misaligned  output  1  sticky: a redirect target had nonzero bits [1:0].
- fetch_count  output  32  number of instructions accepted into IF/ID.

Behaviour:
- Reset (clk edge with reset=1) has top priority: pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0, halted=0, misaligned=0, fetch_count=0. Mid-operation reset discards any pending redirect or stall.
- imem_address = pc, combinational. Fetch latency is one cycle: an instruction addressed in cycle N appears on if_id_* after edge N.
- in_range = (pc[31:2] < IMEM_WORDS). halted = !in_range, combinational from pc.
- Per-edge priority (reset excluded): redirect > stall > halted > normal.
- Redirect:
  - pc <= {redirect_target[31:2], 2'b00}.
  - IF/ID flushed: if_id_valid <= 0, if_id_instr <= NOP_INSTR, if_id_pc_plus4 held.
  - misaligned <= misaligned | (redirect_target[1:0] != 0).
  - fetch_count unchanged.
  - Redirect overrides a simultaneous stall.
- Stall (no redirect): pc, all if_id_* and fetch_count hold their values. Stall while halted is also a hold.
- Halted (no redirect, no stall): pc holds. IF/ID takes a bubble: if_id_valid <= 0, if_id_instr <= NOP_INSTR. imem_instruction is ignored. Only a redirect to an in-range target or reset resumes fetch.
- Normal:
  - pc <= pc + 4, modulo 2^32; wrap is not flagged because the range check catches it first.
  - if_id_instr <= imem_instruction, if_id_pc_plus4 <= pc + 4, if_id_valid <= 1.
  - fetch_count <= fetch_count + 1, wrapping at 2^32.
- Last word: pc = 4*(IMEM_WORDS-1) fetches normally. Next pc = 4*IMEM_WORDS asserts halted in the same cycle that pc is presented.
- misaligned clears only on reset.

Decomposition:
- Shared package (cpu_pkg): word width 32, NOP_INSTR constant, default IMEM_WORDS=1000, and an IF/ID bundle type (instr, pc_plus4, valid) that decode also uses.
- One natural sub-module: if_id_reg, the pipeline register with load/hold/flush controls. The PC register and next-PC mux stay in instruction_fetch.

Test Plan:
- Reset then 3 free-run cycles, memory words 0..2 = A,B,C:
  - imem_address steps 0→4→8→12.
  - if_id_instr = A,B,C with pc_plus4 = 4,8,12 and valid=1.
  - fetch_count = 3.
- Stall for 2 cycles at pc=8:
  - pc stays 8 and if_id_instr stays B for both cycles, fetch_count unchanged.
  - On release, if_id_instr = C and pc = 12.
- Redirect and stall together, target 32'h40, at pc=12:
  - Next pc = 0x40, if_id_valid = 0, if_id_instr = 0.
  - Following cycle if_id_instr = mem[16], pc_plus4 = 0x44.
- Redirect target 32'h43: pc = 0x40 and misaligned = 1. The flag stays 1 through later redirects until reset.
- IMEM_WORDS=1000 with redirect to 3996:
  - Word 999 is fetched, then pc = 4000 with halted = 1.
  - if_id_valid = 0 on every following cycle; pc stays 4000 for 5 cycles.
  - Redirect to 0 clears halted.
- Assert reset mid-redirect at pc=0x40 with stall=1: the next edge gives pc = RESET_PC and every output at its reset value.
